// File: rtl/fwrisc_wb_timer_if.sv
// rtl/fwrisc_wb_timer_if.sv - Wishbone classic-cycle bus bundle for the machine timer
//
// Purpose: groups the Wishbone target-side signals of fwrisc_wb_timer.
// Signals:
//   adr    byte address (only adr[4:2] decoded by the timer)
//   dat_w  write data from the initiator
//   dat_r  read data, valid while ack=1
//   cyc    bus cycle active
//   stb    strobe; a request is cyc & stb
//   we     1=write, 0=read
//   sel    byte enables for writes
//   ack    one-cycle completion pulse
//   err    one-cycle error pulse
// Modports: master (initiator side), slave (timer side).

interface fwrisc_wb_timer_if #(
  parameter int ADDR_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] adr;
  logic [31:0]           dat_w;
  logic [31:0]           dat_r;
  logic                  cyc;
  logic                  stb;
  logic                  we;
  logic [3:0]            sel;
  logic                  ack;
  logic                  err;

  modport master (
    output adr, dat_w, cyc, stb, we, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  adr, dat_w, cyc, stb, we, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/fwrisc_wb_timer.sv
// rtl/fwrisc_wb_timer.sv - Wishbone target with 64-bit machine timer, compare and irq
//
// Purpose: 64-bit mtime counter advanced by a prescaler, 64-bit mtimecmp, a sticky
//   pending flag set whenever mtime >= mtimecmp, and a level interrupt
//   irq = pending & irq_en. Registers are reached over single Wishbone classic
//   cycles with one wait state.
// Ports:
//   clock  single rising-edge clock
//   reset  asynchronous active-high reset, clears all state
//   wbt    Wishbone target bundle (fwrisc_wb_timer_if.slave)
//   irq    timer interrupt level
// Register map (adr[4:2]):
//   0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI,
//   4 CTRL {[1] irq_en, [0] enable}, 5 STATUS {[0] pending, write-1-to-clear},
//   6,7 unmapped.
// Build option: FWRISC_WB_TIMER_ERR_EN defined -> unmapped accesses answer with
//   err instead of ack; undefined -> err stays 0, unmapped accesses ack with 0.

module fwrisc_wb_timer #(
  parameter int ADDR_WIDTH = 32,
  parameter int PRESCALE   = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  fwrisc_wb_timer_if.slave     wbt,
  output logic                 irq
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_t;

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_t       state;
  state_t       state_nx;
  logic         sample;

  logic [63:0]  mtime;
  logic [63:0]  mtime_nx;
  logic [63:0]  mtimecmp;
  logic [15:0]  presc;
  logic [15:0]  presc_nx;
  logic         enable;
  logic         irq_en;
  logic         pending;
  logic         pending_nx;

  logic         ack_q;
  logic         err_q;
  logic [31:0]  dat_r_q;

  logic [2:0]   idx;
  logic         mapped;
  logic         resp_err;
  logic         wr;
  logic         wr_mtime_lo;
  logic         wr_mtime_hi;
  logic         wr_cmp_lo;
  logic         wr_cmp_hi;
  logic         wr_ctrl;
  logic         status_clr;
  logic         compare_hit;
  logic [31:0]  rd_val;

  logic         unused_adr_bits;
  assign unused_adr_bits = ^{wbt.adr[ADDR_WIDTH-1:5], wbt.adr[1:0]};

  function automatic logic [31:0] merge_lanes(input logic [31:0] cur,
                                              input logic [31:0] wdat,
                                              input logic [3:0]  sel);
    logic [31:0] r;
    r = cur;
    for (int i = 0; i < 4; i++) begin
      if (sel[i]) r[8*i +: 8] = wdat[8*i +: 8];
    end
    return r;
  endfunction

  // Address decode
  assign idx    = wbt.adr[4:2];
  assign mapped = (idx <= 3'd5);

`ifdef FWRISC_WB_TIMER_ERR_EN
  assign resp_err = ~mapped;
`else
  assign resp_err = 1'b0;
`endif

  // Unmapped writes are discarded in both builds.
  assign wr          = sample & wbt.we & mapped;
  assign wr_mtime_lo = wr & (idx == 3'd0);
  assign wr_mtime_hi = wr & (idx == 3'd1);
  assign wr_cmp_lo   = wr & (idx == 3'd2);
  assign wr_cmp_hi   = wr & (idx == 3'd3);
  assign wr_ctrl     = wr & (idx == 3'd4) & wbt.sel[0];
  assign status_clr  = wr & (idx == 3'd5) & wbt.sel[0] & wbt.dat_w[0];

  assign compare_hit = (mtime >= mtimecmp);

  // Bus FSM: request is only looked at in IDLE, RESP always lasts one cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    sample   = 1'b0;
    case (state)
      IDLE: begin
        if (wbt.cyc && wbt.stb) begin
          sample   = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Read mux, evaluated on pre-update register values.
  always_comb begin
    rd_val = 32'd0;
    case (idx)
      3'd0: rd_val = mtime[31:0];
      3'd1: rd_val = mtime[63:32];
      3'd2: rd_val = mtimecmp[31:0];
      3'd3: rd_val = mtimecmp[63:32];
      3'd4: rd_val = {30'd0, irq_en, enable};
      3'd5: rd_val = {31'd0, pending};
      default: rd_val = 32'd0;
    endcase
  end

  // A write to either mtime half takes priority over counting and restarts
  // the prescaler so the written value is seen for a full tick period.
  always_comb begin
    mtime_nx = mtime;
    presc_nx = presc;
    if (wr_mtime_lo || wr_mtime_hi) begin
      if (wr_mtime_lo) mtime_nx[31:0]  = merge_lanes(mtime[31:0],  wbt.dat_w, wbt.sel);
      if (wr_mtime_hi) mtime_nx[63:32] = merge_lanes(mtime[63:32], wbt.dat_w, wbt.sel);
      presc_nx = 16'd0;
    end else if (enable) begin
      if (presc == PRESC_LAST) begin
        presc_nx = 16'd0;
        mtime_nx = mtime + 64'd1;
      end else begin
        presc_nx = presc + 16'd1;
      end
    end
  end

  // Set beats clear when both happen in the same cycle.
  always_comb begin
    pending_nx = pending;
    if (status_clr)  pending_nx = 1'b0;
    if (compare_hit) pending_nx = 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mtime    <= 64'd0;
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      presc    <= 16'd0;
      enable   <= 1'b0;
      irq_en   <= 1'b0;
      pending  <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_r_q  <= 32'd0;
    end else begin
      mtime   <= mtime_nx;
      presc   <= presc_nx;
      pending <= pending_nx;
      if (wr_cmp_lo) mtimecmp[31:0]  <= merge_lanes(mtimecmp[31:0],  wbt.dat_w, wbt.sel);
      if (wr_cmp_hi) mtimecmp[63:32] <= merge_lanes(mtimecmp[63:32], wbt.dat_w, wbt.sel);
      if (wr_ctrl) begin
        enable <= wbt.dat_w[0];
        irq_en <= wbt.dat_w[1];
      end
      ack_q <= sample & ~resp_err;
      err_q <= sample & resp_err;
      if (sample) dat_r_q <= mapped ? rd_val : 32'd0;
    end
  end

  assign wbt.ack   = ack_q;
  assign wbt.err   = err_q;
  assign wbt.dat_r = dat_r_q;
  assign irq       = pending & irq_en;

endmodule

// File: tb/tb_fwrisc_wb_timer.sv
// tb/tb_fwrisc_wb_timer.sv - self-checking bench for fwrisc_wb_timer

module tb_fwrisc_wb_timer;
  localparam int PRESCALE = 4;
`ifdef FWRISC_WB_TIMER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic irq;
  int   checks = 0;
  int   errors = 0;
  bit   chk_on = 1'b0;

  fwrisc_wb_timer_if #(.ADDR_WIDTH(32)) wbt();

  fwrisc_wb_timer #(.ADDR_WIDTH(32), .PRESCALE(PRESCALE)) dut (
    .clock (clock),
    .reset (reset),
    .wbt   (wbt),
    .irq   (irq)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: registers as plain numbers, prescaler as a tick count.
  logic [63:0] m_mtime, m_cmp, m_nxt;
  int          m_tick;
  bit          m_en, m_ie, m_pend, m_busy, m_cmp_true, m_mt_wr, m_clr, m_old_en;
  bit          e_ack, e_err;
  logic [31:0] e_dat;
  int          m_idx;

  function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    for (int i = 0; i < 4; i++) if (s[i]) old[8*i +: 8] = d[8*i +: 8];
    return old;
  endfunction

  function automatic logic [31:0] model_read(input int i);
    case (i)
      0: return m_mtime[31:0];
      1: return m_mtime[63:32];
      2: return m_cmp[31:0];
      3: return m_cmp[63:32];
      4: return {30'd0, m_ie, m_en};
      5: return {31'd0, m_pend};
      default: return 32'd0;
    endcase
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_mtime = 64'd0; m_cmp = '1; m_tick = 0; m_en = 0; m_ie = 0; m_pend = 0;
      m_busy = 0; e_ack = 0; e_err = 0; e_dat = 32'd0;
    end else begin
      m_cmp_true = (m_mtime >= m_cmp);
      m_old_en   = m_en;
      m_mt_wr    = 0;
      m_clr      = 0;
      m_nxt      = m_mtime;
      if (m_busy) begin
        m_busy = 0; e_ack = 0; e_err = 0;
      end else if (wbt.cyc && wbt.stb) begin
        m_busy = 1;
        m_idx  = int'(wbt.adr[4:2]);
        if (m_idx > 5 && ERR_EN) begin
          e_err = 1; e_ack = 0; e_dat = 32'd0;
        end else begin
          e_ack = 1; e_err = 0; e_dat = model_read(m_idx);
          if (wbt.we) begin
            case (m_idx)
              0: begin m_nxt[31:0]  = lanes(m_mtime[31:0],  wbt.dat_w, wbt.sel); m_mt_wr = 1; end
              1: begin m_nxt[63:32] = lanes(m_mtime[63:32], wbt.dat_w, wbt.sel); m_mt_wr = 1; end
              2: m_cmp[31:0]  = lanes(m_cmp[31:0],  wbt.dat_w, wbt.sel);
              3: m_cmp[63:32] = lanes(m_cmp[63:32], wbt.dat_w, wbt.sel);
              4: if (wbt.sel[0]) begin m_en = wbt.dat_w[0]; m_ie = wbt.dat_w[1]; end
              5: m_clr = wbt.sel[0] && wbt.dat_w[0];
              default: ;
            endcase
          end
        end
      end
      if (m_mt_wr) begin
        m_mtime = m_nxt; m_tick = 0;
      end else if (m_old_en) begin
        m_tick++;
        if (m_tick == PRESCALE) begin m_tick = 0; m_mtime = m_mtime + 64'd1; end
      end
      if (m_clr) m_pend = 0;
      if (m_cmp_true) m_pend = 1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clock) begin
    if (!reset && chk_on) begin
      check("ack", 64'(wbt.ack), 64'(e_ack));
      check("err", 64'(wbt.err), 64'(e_err));
      if (e_ack) check("dat_r", 64'(wbt.dat_r), 64'(e_dat));
      check("irq", 64'(irq), 64'(m_pend & m_ie));
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic access(input logic [31:0] a, input bit we, input logic [31:0] d,
                        input logic [3:0] s, output logic [31:0] rd,
                        output bit got_ack, output bit got_err, output int lat);
    wbt.adr = a; wbt.we = we; wbt.dat_w = d; wbt.sel = s; wbt.cyc = 1; wbt.stb = 1;
    lat = 0; got_ack = 0; got_err = 0; rd = 32'd0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clock);
      if (wbt.ack || wbt.err) begin
        lat = i; got_ack = wbt.ack; got_err = wbt.err; rd = wbt.dat_r;
        break;
      end
    end
    wbt.cyc = 0; wbt.stb = 0;
    if (lat == 0) begin
      checks++; errors++;
      $display("FAIL bus_timeout: got no response expected ack/err at adr %h", a);
    end
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r; bit ak, er; int l;
    access(a, 1'b1, d, s, r, ak, er, l);
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] r);
    bit ak, er; int l;
    access(a, 1'b0, 32'd0, 4'hF, r, ak, er, l);
  endtask

  logic [31:0] rv;
  logic [31:0] exp_rst [6];
  bit          ak, er;
  int          lat;
  int          waited;

  initial begin
    exp_rst = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    wbt.adr = '0; wbt.dat_w = '0; wbt.cyc = 0; wbt.stb = 0; wbt.we = 0; wbt.sel = '0;
    reset = 1;
    repeat (3) @(negedge clock);
    reset = 0;
    check("rst_ack", 64'(wbt.ack), 64'd0);
    check("rst_err", 64'(wbt.err), 64'd0);
    check("rst_dat_r", 64'(wbt.dat_r), 64'd0);
    check("rst_irq", 64'(irq), 64'd0);
    chk_on = 1;

    for (int i = 0; i < 6; i++) begin
      rd(32'(i * 4), rv);
      check($sformatf("rst_reg%0d", i), 64'(rv), 64'(exp_rst[i]));
    end

    // Latency of a single read
    idle(1);
    access(32'h08, 1'b0, 32'd0, 4'hF, rv, ak, er, lat);
    check("lat_ack", 64'(lat), 64'd1);
    check("lat_dat", 64'(rv), 64'hFFFF_FFFF);

    // Strobe held across three requests
    idle(1);
    wbt.adr = 32'h0; wbt.we = 0; wbt.cyc = 1; wbt.stb = 1;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge clock);
      check($sformatf("b2b_ack%0d", i), 64'(wbt.ack), 64'(i % 2));
    end
    wbt.cyc = 0; wbt.stb = 0;

    // Byte lanes
    wr(32'h08, 32'h1122_3344, 4'b0101);
    rd(32'h08, rv);
    check("byte_lanes", 64'(rv), 64'hFF22_FF44);
    wr(32'h08, 32'hFFFF_FFFF, 4'hF);

    // Full 64-bit wrap: 8 enabled cycles at PRESCALE=4 is two ticks
    wr(32'h00, 32'hFFFF_FFFE, 4'hF);
    wr(32'h04, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    idle(7);
    wr(32'h10, 32'h0, 4'hF);
    rd(32'h00, rv); check("wrap_lo", 64'(rv), 64'd0);
    rd(32'h04, rv); check("wrap_hi", 64'(rv), 64'd0);

    // Carry from LO into HI: one tick
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h00, 32'hFFFF_FFFF, 4'hF);
    wr(32'h10, 32'h1, 4'hF);
    idle(3);
    wr(32'h10, 32'h0, 4'hF);
    rd(32'h00, rv); check("carry_lo", 64'(rv), 64'd0);
    rd(32'h04, rv); check("carry_hi", 64'(rv), 64'd1);

    // Interrupt
    wr(32'h0C, 32'h0, 4'hF);
    wr(32'h08, 32'd10, 4'hF);
    wr(32'h04, 32'h0, 4'hF);
    wr(32'h00, 32'h0, 4'hF);
    wr(32'h14, 32'h1, 4'hF);
    rd(32'h14, rv); check("irq_pend_clear", 64'(rv), 64'd0);
    wr(32'h10, 32'h3, 4'hF);
    waited = 0;
    while (!irq && waited < 200) begin @(negedge clock); waited++; end
    check("irq_rise", 64'(irq), 64'd1);
    wr(32'h14, 32'h1, 4'hF);
    rd(32'h14, rv); check("w1c_set_wins", 64'(rv), 64'd1);
    wr(32'h08, 32'd100, 4'hF);
    wr(32'h14, 32'h1, 4'hF);
    check("irq_cleared", 64'(irq), 64'd0);
    wr(32'h10, 32'h0, 4'hF);

    // Unmapped address
    access(32'h18, 1'b0, 32'd0, 4'hF, rv, ak, er, lat);
    check("unmapped_ack", 64'(ak), 64'(!ERR_EN));
    check("unmapped_err", 64'(er), 64'(ERR_EN));
    check("unmapped_dat", 64'(rv), 64'd0);

    // Reset during the response cycle
    idle(1);
    wbt.adr = 32'h08; wbt.we = 0; wbt.cyc = 1; wbt.stb = 1;
    @(posedge clock); #1;
    wbt.cyc = 0; wbt.stb = 0;
    check("pre_reset_ack", 64'(wbt.ack), 64'd1);
    reset = 1; #1;
    check("abort_ack", 64'(wbt.ack), 64'd0);
    check("abort_err", 64'(wbt.err), 64'd0);
    repeat (2) @(negedge clock);
    reset = 0;
    rd(32'h08, rv); check("post_reset_cmp", 64'(rv), 64'hFFFF_FFFF);

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 400; n++) begin
      logic [31:0] a, d;
      int sel_reg;
      idle($urandom_range(0, 2));
      sel_reg = $urandom_range(0, 7);
      a = ($urandom & 32'hFFFF_FFE0) | 32'(sel_reg * 4) | 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: d = 32'hFFFF_FFFF - 32'($urandom_range(0, 3));
        1: d = 32'($urandom_range(0, 40));
        default: d = $urandom;
      endcase
      access(a, 1'($urandom_range(0, 1)), d, 4'($urandom_range(0, 15)), rv, ak, er, lat);
    end

    idle(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got no finish expected end of test");
    $fatal(1);
  end

endmodule
